aes_128_key_sched_4cyc: RTL

Round-key scheduler sitting directly upstream of the 4-cycle AES-128 core. Accepts a 128-bit cipher key and expands it into the 11 round keys (FIPS-197). Stores them locally and presents them one at a time on `key_round`, advancing each time the core pulses `key_ready`. This lets the core encrypt back-to-back blocks under one key without re-expansion.

---
 rtl/aes_128_key_sched_4cyc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/aes_128_key_sched_4cyc.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_key_sched_4cyc
// Description : AES-128 round-key scheduler. Expands a cipher key into the
//               11 round keys, one per cycle, stores them, and serves them one
//               at a time to the cipher core, advancing on each key_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_key_sched_4cyc (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         key_ready,
    output logic [127:0] key_round,
    output logic         key_valid,
    output logic         busy,
    output logic         key_underrun_irq_pulse
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EXPAND = 2'd1;
    localparam logic [1:0] c_ST_READY  = 2'd2;

    localparam logic [3:0] c_LAST_RND  = 4'd10;

    // S-box table, entry 0 in the top byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x lives at bit offset 8*(255-x); for an 8-bit x, 255-x == ~x.
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return c_SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [127:0] r_rk [0:10];
    logic [3:0]   r_ptr;
    logic [3:0]   r_rnd;
    logic         r_underrun;

    logic [127:0] w_prev;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic [127:0] w_next_rk;

    // Select rk[rnd-1], the key the current expansion step builds on.
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < 10; i++) begin
            if (r_rnd == 4'(i + 1)) w_prev = r_rk[i];
        end
    end

    assign w_rot = {w_prev[23:0], w_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub[8*g +: 8] = f_sbox(w_rot[8*g +: 8]);
    end

    assign w_t       = w_sub ^ {f_rcon(r_rnd), 24'h0};
    assign w_w4      = w_prev[127:96] ^ w_t;
    assign w_w5      = w_w4 ^ w_prev[95:64];
    assign w_w6      = w_w5 ^ w_prev[63:32];
    assign w_w7      = w_w6 ^ w_prev[31:0];
    assign w_next_rk = {w_w4, w_w5, w_w6, w_w7};

    // Serve rk[ptr]; ptr never leaves 0..10, the default only keeps the mux total.
    always_comb begin
        key_round = '0;
        for (int i = 0; i < 11; i++) begin
            if (r_ptr == 4'(i)) key_round = r_rk[i];
        end
    end

    // Next-state and status decode; a load restarts expansion from any state.
    always_comb begin
        w_state_nxt = r_state;
        key_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            c_ST_IDLE: ;
            c_ST_EXPAND: begin
                busy = 1'b1;
                if (r_rnd == c_LAST_RND) w_state_nxt = c_ST_READY;
            end
            c_ST_READY: key_valid = 1'b1;
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (key_load) w_state_nxt = c_ST_EXPAND;
    end

    assign key_underrun_irq_pulse = r_underrun;

    // State, key storage, round counter, round pointer and underrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_ptr      <= '0;
            r_rnd      <= '0;
            r_underrun <= 1'b0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_underrun <= key_ready && !key_valid;
            if (key_load) begin
                r_rk[0] <= key_in;
                r_ptr   <= '0;
                r_rnd   <= 4'd1;
            end else begin
                if (r_state == c_ST_EXPAND) begin
                    for (int i = 1; i < 11; i++) begin
                        if (r_rnd == 4'(i)) r_rk[i] <= w_next_rk;
                    end
                    r_rnd <= r_rnd + 4'd1;
                end
                // kill outranks key_ready; ready is only honoured while serving.
                if (kill) begin
                    r_ptr <= '0;
                end else if (key_ready && r_state == c_ST_READY) begin
                    r_ptr <= (r_ptr == c_LAST_RND) ? 4'd0 : r_ptr + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
